// File: rtl/ysyx_22050078_lsu_if.sv
// Bundles the execute-side handshake, the write-back handshake and the data-memory port of the LSU.
// The master modport is the LSU's view; the slave modport is its environment's view.
interface ysyx_22050078_lsu_if #(
  parameter int CPU_WIDTH = 64,
  parameter int OPT_WIDTH = 4
) ();
  logic                   i_valid;
  logic                   o_ready;
  logic [CPU_WIDTH-1:0]   i_exu_res;
  logic [CPU_WIDTH-1:0]   i_rs2_data;
  logic [OPT_WIDTH-1:0]   i_lsu_opt;
  logic                   o_valid;
  logic                   i_ready;
  logic [CPU_WIDTH-1:0]   o_lsu_res;
  logic                   o_misalign;
  logic                   o_mem_req;
  logic                   o_mem_we;
  logic [CPU_WIDTH-1:0]   o_mem_addr;
  logic [CPU_WIDTH-1:0]   o_mem_wdata;
  logic [CPU_WIDTH/8-1:0] o_mem_wmask;
  logic                   i_mem_gnt;
  logic                   i_mem_rvalid;
  logic [CPU_WIDTH-1:0]   i_mem_rdata;

  modport master (
    input  i_valid, i_exu_res, i_rs2_data, i_lsu_opt, i_ready,
           i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    output o_ready, o_valid, o_lsu_res, o_misalign,
           o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask
  );

  modport slave (
    output i_valid, i_exu_res, i_rs2_data, i_lsu_opt, i_ready,
           i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    input  o_ready, o_valid, o_lsu_res, o_misalign,
           o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask
  );
endinterface

// File: rtl/ysyx_22050078_lsu.sv
// Multi-cycle load/store unit: one outstanding operation, request/grant/response on the memory port,
// lane-shifted stores and aligned, sign/zero-extended loads presented to write-back.
module ysyx_22050078_lsu #(
  parameter int CPU_WIDTH = 64,
  parameter int OPT_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  ysyx_22050078_lsu_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [OPT_WIDTH-1:0]   opt_q, opt_d;
  logic [2:0]             off_q, off_d;
  logic [CPU_WIDTH-1:0]   addr_q, addr_d;
  logic [CPU_WIDTH-1:0]   wdata_q, wdata_d;
  logic [7:0]             wmask_q, wmask_d;
  logic                   we_q, we_d;
  logic [CPU_WIDTH-1:0]   res_q, res_d;
  logic                   mis_q, mis_d;

  logic                   in_load_s, in_store_s, in_mis_s;
  logic [1:0]             in_size_s;
  logic [2:0]             in_off_s, size_mask_s;
  logic [7:0]             base_mask_s;

  function automatic logic [CPU_WIDTH-1:0] load_ext(input logic [OPT_WIDTH-1:0] opt,
                                                    input logic [2:0] off,
                                                    input logic [CPU_WIDTH-1:0] rdata);
    logic [CPU_WIDTH-1:0] sh;
    sh = rdata >> {off, 3'b000};
    case (opt)
      4'd1:    load_ext = {{(CPU_WIDTH-8){sh[7]}}, sh[7:0]};
      4'd2:    load_ext = {{(CPU_WIDTH-16){sh[15]}}, sh[15:0]};
      4'd3:    load_ext = {{(CPU_WIDTH-32){sh[31]}}, sh[31:0]};
      4'd5:    load_ext = {{(CPU_WIDTH-8){1'b0}}, sh[7:0]};
      4'd6:    load_ext = {{(CPU_WIDTH-16){1'b0}}, sh[15:0]};
      4'd7:    load_ext = {{(CPU_WIDTH-32){1'b0}}, sh[31:0]};
      default: load_ext = sh;
    endcase
  endfunction

  // Decode the incoming opcode: kind, access size and natural-alignment check.
  always_comb begin
    in_load_s  = 1'b0;
    in_store_s = 1'b0;
    in_size_s  = 2'd0;
    case (bus.i_lsu_opt)
      4'd1, 4'd5: begin in_load_s = 1'b1; in_size_s = 2'd0; end
      4'd2, 4'd6: begin in_load_s = 1'b1; in_size_s = 2'd1; end
      4'd3, 4'd7: begin in_load_s = 1'b1; in_size_s = 2'd2; end
      4'd4:       begin in_load_s = 1'b1; in_size_s = 2'd3; end
      4'd8:       begin in_store_s = 1'b1; in_size_s = 2'd0; end
      4'd9:       begin in_store_s = 1'b1; in_size_s = 2'd1; end
      4'd10:      begin in_store_s = 1'b1; in_size_s = 2'd2; end
      4'd11:      begin in_store_s = 1'b1; in_size_s = 2'd3; end
      default:    begin in_load_s = 1'b0; in_store_s = 1'b0; end
    endcase
    case (in_size_s)
      2'd0:    begin size_mask_s = 3'b000; base_mask_s = 8'h01; end
      2'd1:    begin size_mask_s = 3'b001; base_mask_s = 8'h03; end
      2'd2:    begin size_mask_s = 3'b011; base_mask_s = 8'h0F; end
      default: begin size_mask_s = 3'b111; base_mask_s = 8'hFF; end
    endcase
    in_off_s = bus.i_exu_res[2:0];
    in_mis_s = (in_load_s | in_store_s) & (|(in_off_s & size_mask_s));
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; gnt and rvalid only matter in the state that waits for them.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_valid) begin
          state_d = ((in_load_s | in_store_s) && !in_mis_s) ? S_REQ : S_RESP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (bus.i_mem_gnt) begin
          state_d = we_q ? S_RESP : S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (bus.i_mem_rvalid) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        if (bus.i_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: capture at accept, load result at rvalid, otherwise hold.
  always_comb begin
    opt_d   = opt_q;
    off_d   = off_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    we_d    = we_q;
    res_d   = res_q;
    mis_d   = mis_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_valid) begin
          opt_d   = bus.i_lsu_opt;
          off_d   = in_off_s;
          addr_d  = {bus.i_exu_res[CPU_WIDTH-1:3], 3'b000};
          wdata_d = bus.i_rs2_data << {in_off_s, 3'b000};
          wmask_d = in_store_s ? (base_mask_s << in_off_s) : 8'h00;
          we_d    = in_store_s;
          mis_d   = in_mis_s;
          res_d   = (in_load_s | in_store_s) ? {CPU_WIDTH{1'b0}} : bus.i_exu_res;
        end else begin
          opt_d = opt_q;
        end
      end
      S_WAIT: begin
        if (bus.i_mem_rvalid) begin
          res_d = load_ext(opt_q, off_q, bus.i_mem_rdata);
        end else begin
          res_d = res_q;
        end
      end
      default: begin
        res_d = res_q;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      opt_q   <= {OPT_WIDTH{1'b0}};
      off_q   <= 3'd0;
      addr_q  <= {CPU_WIDTH{1'b0}};
      wdata_q <= {CPU_WIDTH{1'b0}};
      wmask_q <= 8'h00;
      we_q    <= 1'b0;
      res_q   <= {CPU_WIDTH{1'b0}};
      mis_q   <= 1'b0;
    end else begin
      opt_q   <= opt_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      we_q    <= we_d;
      res_q   <= res_d;
      mis_q   <= mis_d;
    end
  end

  // Outputs come straight from registered state and datapath.
  always_comb begin
    bus.o_ready     = (state_q == S_IDLE);
    bus.o_mem_req   = (state_q == S_REQ);
    bus.o_valid     = (state_q == S_RESP);
    bus.o_mem_we    = we_q;
    bus.o_mem_addr  = addr_q;
    bus.o_mem_wdata = wdata_q;
    bus.o_mem_wmask = wmask_q;
    bus.o_lsu_res   = res_q;
    bus.o_misalign  = mis_q;
  end

endmodule

// File: tb/tb_ysyx_22050078_lsu.sv
// Self-checking bench for ysyx_22050078_lsu: directed test-plan cases, a reset-abort case and
// randomized operations, all checked against a byte-level reference model.
module tb_ysyx_22050078_lsu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_22050078_lsu_if bus ();

  ysyx_22050078_lsu dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.master)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int nb_tab[16] = '{0, 1, 2, 4, 8, 1, 2, 4, 1, 2, 4, 8, 0, 0, 0, 0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: 0 none, 1 load, 2 store
  function automatic int kind_of(input logic [3:0] opt);
    if (opt >= 4'd1 && opt <= 4'd7) return 1;
    if (opt >= 4'd8 && opt <= 4'd11) return 2;
    return 0;
  endfunction

  function automatic logic [63:0] model_load(input logic [3:0] opt, input int off, input logic [63:0] rdata);
    logic [63:0] v;
    int n;
    n = nb_tab[opt];
    v = 64'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rdata[8*(off+i) +: 8];
    if (opt >= 4'd1 && opt <= 4'd3 && v[8*n-1]) begin
      for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] rs2, input int off);
    logic [63:0] w;
    w = 64'd0;
    for (int i = 0; i < 8; i++) if (i >= off) w[8*i +: 8] = rs2[8*(i-off) +: 8];
    return w;
  endfunction

  function automatic logic [7:0] model_wmask(input logic [3:0] opt, input int off);
    logic [7:0] m;
    m = 8'd0;
    if (kind_of(opt) == 2) begin
      for (int i = 0; i < 8; i++) if (i >= off && i < off + nb_tab[opt]) m[i] = 1'b1;
    end
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_ready"}, bus.o_ready, 64'd1);
    chk({pfx, "_valid"}, bus.o_valid, 64'd0);
    chk({pfx, "_mis"}, bus.o_misalign, 64'd0);
    chk({pfx, "_req"}, bus.o_mem_req, 64'd0);
    chk({pfx, "_we"}, bus.o_mem_we, 64'd0);
    chk({pfx, "_res"}, bus.o_lsu_res, 64'd0);
    chk({pfx, "_addr"}, bus.o_mem_addr, 64'd0);
    chk({pfx, "_wdata"}, bus.o_mem_wdata, 64'd0);
    chk({pfx, "_wmask"}, {56'd0, bus.o_mem_wmask}, 64'd0);
  endtask

  // One complete operation with chosen grant/rvalid/ready delays.
  task automatic do_op(input logic [3:0] opt, input logic [63:0] addr, input logic [63:0] rs2,
                       input logic [63:0] rdata, input int gdly, input int rdly, input int hold,
                       input bit stray);
    int kind, n, off;
    bit mis;
    logic [63:0] exp_res;
    kind = kind_of(opt);
    n    = nb_tab[opt];
    off  = int'(addr[2:0]);
    mis  = (kind != 0) && ((off % n) != 0);
    chk("idle_ready", bus.o_ready, 64'd1);
    bus.i_valid    = 1'b1;
    bus.i_lsu_opt  = opt;
    bus.i_exu_res  = addr;
    bus.i_rs2_data = rs2;
    step();
    bus.i_valid    = 1'b0;
    bus.i_exu_res  = {$urandom, $urandom};
    bus.i_rs2_data = {$urandom, $urandom};
    bus.i_lsu_opt  = 4'($urandom_range(0, 15));
    if (kind == 0) exp_res = addr;
    else exp_res = 64'd0;
    if (kind != 0 && !mis) begin
      for (int d = 0; d <= gdly; d++) begin
        chk("req", bus.o_mem_req, 64'd1);
        chk("req_ready", bus.o_ready, 64'd0);
        chk("req_addr", bus.o_mem_addr, {addr[63:3], 3'b000});
        chk("req_we", bus.o_mem_we, (kind == 2) ? 64'd1 : 64'd0);
        chk("req_wdata", bus.o_mem_wdata, model_wdata(rs2, off));
        chk("req_wmask", {56'd0, bus.o_mem_wmask}, {56'd0, model_wmask(opt, off)});
        if (d == gdly) bus.i_mem_gnt = 1'b1;
        else if (stray) begin
          bus.i_mem_rvalid = 1'b1;
          bus.i_mem_rdata  = {$urandom, $urandom};
        end
        step();
        bus.i_mem_gnt    = 1'b0;
        bus.i_mem_rvalid = 1'b0;
      end
      if (kind == 1) begin
        for (int d = 0; d <= rdly; d++) begin
          chk("wait_req", bus.o_mem_req, 64'd0);
          chk("wait_valid", bus.o_valid, 64'd0);
          if (d == rdly) begin
            bus.i_mem_rvalid = 1'b1;
            bus.i_mem_rdata  = rdata;
          end else begin
            bus.i_mem_gnt = stray;
          end
          step();
          bus.i_mem_rvalid = 1'b0;
          bus.i_mem_gnt    = 1'b0;
          bus.i_mem_rdata  = {$urandom, $urandom};
        end
        exp_res = model_load(opt, off, rdata);
      end
    end
    for (int h = 0; h <= hold; h++) begin
      chk("resp_valid", bus.o_valid, 64'd1);
      chk("resp_res", bus.o_lsu_res, exp_res);
      chk("resp_mis", bus.o_misalign, mis ? 64'd1 : 64'd0);
      chk("resp_req", bus.o_mem_req, 64'd0);
      if (h == hold) bus.i_ready = 1'b1;
      step();
      bus.i_ready = 1'b0;
    end
    chk("done_valid", bus.o_valid, 64'd0);
    chk("done_ready", bus.o_ready, 64'd1);
  endtask

  initial begin
    logic [3:0]  r_opt;
    logic [63:0] r_addr;
    int          r_nb;
    bus.i_valid      = 1'b0;
    bus.i_exu_res    = 64'd0;
    bus.i_rs2_data   = 64'd0;
    bus.i_lsu_opt    = 4'd0;
    bus.i_ready      = 1'b0;
    bus.i_mem_gnt    = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = 64'd0;

    step();
    step();
    check_reset_values("rst");
    rst_n = 1'b1;
    step();
    check_reset_values("post_rst");

    // Directed test-plan cases
    do_op(4'd0,  64'h1234_5678_9ABC_DEF0, 64'd0, 64'd0, 0, 0, 0, 1'b0);
    do_op(4'd1,  64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 0, 0, 1'b0);
    do_op(4'd5,  64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 0, 0, 1'b0);
    do_op(4'd9,  64'h8000_0006, 64'h0000_0000_0000_ABCD, 64'd0, 0, 0, 0, 1'b0);
    do_op(4'd3,  64'h8000_0002, 64'd0, 64'd0, 0, 0, 0, 1'b0);
    do_op(4'd4,  64'h8000_0008, 64'd0, 64'hFEDC_BA98_7654_3210, 3, 0, 2, 1'b1);
    do_op(4'd13, 64'hDEAD_BEEF_0000_0001, 64'd0, 64'd0, 0, 0, 1, 1'b0);
    do_op(4'd11, 64'h8000_0004, 64'h1111_2222_3333_4444, 64'd0, 0, 0, 0, 1'b0);

    // Reset while waiting for load data, then a late rvalid
    bus.i_valid   = 1'b1;
    bus.i_lsu_opt = 4'd3;
    bus.i_exu_res = 64'h8000_0014;
    step();
    bus.i_valid   = 1'b0;
    bus.i_mem_gnt = 1'b1;
    step();
    bus.i_mem_gnt = 1'b0;
    chk("abort_in_wait", bus.o_mem_req, 64'd0);
    rst_n = 1'b0;
    #1;
    check_reset_values("abort");
    step();
    rst_n = 1'b1;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    bus.i_mem_rvalid = 1'b0;
    check_reset_values("late_rvalid");
    step();
    chk("late_rvalid_valid2", bus.o_valid, 64'd0);

    // Randomized operations
    for (int k = 0; k < 60; k++) begin
      r_opt  = 4'($urandom_range(0, 15));
      r_addr = {$urandom, $urandom};
      r_nb   = nb_tab[r_opt];
      if (r_nb > 0 && $urandom_range(0, 3) != 0) r_addr[2:0] = 3'(int'(r_addr[2:0]) / r_nb * r_nb);
      do_op(r_opt, r_addr, {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
